// File: rtl/immediate_pipe.sv
// RISC-V immediate decoder feeding a small in-order result FIFO.
// The decode happens at acceptance; the head entry is driven straight from registered storage.
module immediate_pipe #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 4,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      instruction,
  input  logic [2:0]       imm_fmt,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [XLEN-1:0]  immediate,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       illegal_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_S  = 3'd1,
    FMT_B  = 3'd2,
    FMT_U  = 3'd3,
    FMT_J  = 3'd4,
    FMT_Z  = 3'd5,
    FMT_SH = 3'd6,
    FMT_RS = 3'd7
  } fmt_t;

  logic [XLEN-1:0]  imm_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic             ill_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             active_reg;
  logic [7:0]       illegal_count_reg;

  logic [63:0]      dec_wide;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;
  logic             accept;
  logic             pop;

  // All formats are built at 64 bits and truncated, which keeps XLEN=32 and 64 on one path.
  always_comb begin
    dec_wide    = '0;
    dec_illegal = 1'b0;
    case (fmt_t'(imm_fmt))
      FMT_I:  dec_wide = {{52{instruction[31]}}, instruction[31:20]};
      FMT_S:  dec_wide = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B:  dec_wide = {{51{instruction[31]}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0};
      FMT_U:  dec_wide = {{32{instruction[31]}}, instruction[31:12], 12'b0};
      FMT_J:  dec_wide = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                          instruction[20], instruction[30:21], 1'b0};
      FMT_Z:  dec_wide = {59'b0, instruction[19:15]};
      FMT_SH: dec_wide = {52'b0, instruction[31:20]} & ((64'd1 << SHAMT_W) - 64'd1);
      default: dec_illegal = 1'b1;
    endcase
    dec_imm = dec_wide[XLEN-1:0];
  end

  // in_ready depends only on registers, so out_ready never reaches it combinationally.
  assign in_ready  = active_reg && (count_reg != CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_next = count_reg;
    if (accept && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !accept) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      active_reg        <= 1'b0;
      illegal_count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem[i] <= '0;
        tag_mem[i] <= '0;
        ill_mem[i] <= 1'b0;
      end
    end else begin
      active_reg <= 1'b1;
      count_reg  <= count_next;
      if (accept) begin
        imm_mem[wr_ptr_reg] <= dec_imm;
        tag_mem[wr_ptr_reg] <= in_tag;
        ill_mem[wr_ptr_reg] <= dec_illegal;
        wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
        if (dec_illegal && (illegal_count_reg != 8'hFF)) begin
          illegal_count_reg <= illegal_count_reg + 8'd1;
        end
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  assign immediate     = imm_mem[rd_ptr_reg];
  assign out_tag       = tag_mem[rd_ptr_reg];
  assign out_illegal   = ill_mem[rd_ptr_reg];
  assign illegal_count = illegal_count_reg;

endmodule

// File: tb/tb_immediate_pipe.sv
// Directed bench for immediate_pipe: decode table on 32- and 64-bit instances,
// then hand-written backpressure, streaming, saturation and mid-flight reset sequences.
module tb_immediate_pipe;

  logic        clk;
  logic        reset_n;
  logic [31:0] instruction;
  logic [2:0]  imm_fmt;
  logic [3:0]  in_tag;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready;
  logic [31:0] immediate;
  logic [3:0]  out_tag;
  logic        out_illegal;
  logic        out_valid;
  logic [7:0]  illegal_count;

  logic        in_ready_w;
  logic [63:0] immediate_w;
  logic [3:0]  out_tag_w;
  logic        out_illegal_w;
  logic        out_valid_w;
  logic [7:0]  illegal_count_w;

  int total_checks;
  int passed_checks;

  immediate_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(4), .SHAMT_W(5)) dut32 (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .imm_fmt(imm_fmt),
    .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready), .immediate(immediate),
    .out_tag(out_tag), .out_illegal(out_illegal), .out_valid(out_valid),
    .out_ready(out_ready), .illegal_count(illegal_count)
  );

  immediate_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(4), .SHAMT_W(6)) dut64 (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .imm_fmt(imm_fmt),
    .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready_w), .immediate(immediate_w),
    .out_tag(out_tag_w), .out_illegal(out_illegal_w), .out_valid(out_valid_w),
    .out_ready(out_ready), .illegal_count(illegal_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] instr;
    logic [3:0]  tag;
    logic [31:0] exp32;
    logic [63:0] exp64;
    logic        ill;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act === exp) begin
      passed_checks++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_tag    = '0;
    imm_fmt   = '0;
    instruction = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;

    vecs[0]  = '{3'd0, 32'hFFF00093, 4'd1,  32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{3'd0, 32'h7FF00013, 4'd2,  32'h000007FF, 64'h00000000000007FF, 1'b0};
    vecs[2]  = '{3'd1, 32'h80000FA3, 4'd3,  32'hFFFFF81F, 64'hFFFFFFFFFFFFF81F, 1'b0};
    vecs[3]  = '{3'd2, 32'hFE000EE3, 4'd4,  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[4]  = '{3'd3, 32'h12345037, 4'd5,  32'h12345000, 64'h0000000012345000, 1'b0};
    vecs[5]  = '{3'd3, 32'h80000037, 4'd6,  32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[6]  = '{3'd4, 32'hFFDFF06F, 4'd7,  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[7]  = '{3'd4, 32'h0040006F, 4'd8,  32'h00000004, 64'h0000000000000004, 1'b0};
    vecs[8]  = '{3'd5, 32'h800F8073, 4'd9,  32'h0000001F, 64'h000000000000001F, 1'b0};
    vecs[9]  = '{3'd6, 32'h03F01013, 4'd10, 32'h0000001F, 64'h000000000000003F, 1'b0};
    vecs[10] = '{3'd6, 32'h41F05013, 4'd11, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vecs[11] = '{3'd7, 32'hFFFFFFFF, 4'd12, 32'h00000000, 64'h0000000000000000, 1'b1};

    // Reset state
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_tag = '0;
    imm_fmt = '0;
    instruction = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",    64'(in_ready), 64'd0);
    check("rst_out_valid",   64'(out_valid), 64'd0);
    check("rst_immediate",   64'(immediate), 64'd0);
    check("rst_out_tag",     64'(out_tag), 64'd0);
    check("rst_out_illegal", 64'(out_illegal), 64'd0);
    check("rst_illegal_cnt", 64'(illegal_count), 64'd0);
    check("rst_imm64",       immediate_w, 64'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Decode table, one entry at a time through an empty FIFO
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      instruction = vecs[i].instr;
      imm_fmt     = vecs[i].fmt;
      in_tag      = vecs[i].tag;
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      $display("vec %0d fmt=%0d instr=0x%08h -> imm32=0x%08h imm64=0x%016h tag=%0d ill=%0b",
               i, vecs[i].fmt, vecs[i].instr, immediate, immediate_w, out_tag, out_illegal);
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_imm32", i), 64'(immediate), 64'(vecs[i].exp32));
      check($sformatf("vec%0d_imm64", i), immediate_w, vecs[i].exp64);
      check($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(vecs[i].tag));
      check($sformatf("vec%0d_ill", i), 64'(out_illegal), 64'(vecs[i].ill));
      tick();
      check($sformatf("vec%0d_drained", i), 64'(out_valid), 64'd0);
    end
    check("table_illegal_cnt", 64'(illegal_count), 64'd1);
    check("table_illegal_cnt64", 64'(illegal_count_w), 64'd1);

    // Backpressure: fill, hold, drain; a pop while full must not admit a new entry
    do_reset();
    instruction = 32'h00500013;
    imm_fmt = 3'd0;
    in_valid = 1'b1;
    in_tag = 4'd1;
    tick();
    $display("bp accept tag1: in_ready=%0b out_tag=%0d", in_ready, out_tag);
    check("bp_ready_after1", 64'(in_ready), 64'd1);
    check("bp_head_after1", 64'(out_tag), 64'd1);
    in_tag = 4'd2;
    tick();
    $display("bp accept tag2: in_ready=%0b out_tag=%0d", in_ready, out_tag);
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_full_valid", 64'(out_valid), 64'd1);
    in_tag = 4'd3;
    tick();
    $display("bp hold: in_ready=%0b out_tag=%0d imm=0x%0h", in_ready, out_tag, immediate);
    check("bp_hold_tag", 64'(out_tag), 64'd1);
    check("bp_hold_imm", 64'(immediate), 64'd5);
    check("bp_hold_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    $display("bp pop1: in_ready=%0b out_tag=%0d", in_ready, out_tag);
    check("bp_pop1_tag", 64'(out_tag), 64'd2);
    check("bp_pop1_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    tick();
    $display("bp pop2: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    check("bp_no_late_accept", 64'(out_valid), 64'd0);
    check("bp_ready_back", 64'(in_ready), 64'd1);

    // Streaming: accept and pop every cycle, one entry resident
    do_reset();
    out_ready = 1'b1;
    imm_fmt = 3'd0;
    in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_tag = 4'(k);
      instruction = 32'(k) << 20;
      tick();
      $display("stream %0d: out_valid=%0b tag=%0d imm=0x%0h in_ready=%0b",
               k, out_valid, out_tag, immediate, in_ready);
      check($sformatf("stream%0d_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("stream%0d_tag", k), 64'(out_tag), 64'(k));
      check($sformatf("stream%0d_imm", k), 64'(immediate), 64'(k));
      check($sformatf("stream%0d_ready", k), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 64'(out_valid), 64'd0);

    // Illegal format saturation
    do_reset();
    out_ready = 1'b1;
    imm_fmt = 3'd7;
    instruction = 32'hFFFFFFFF;
    in_valid = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      in_tag = 4'(n);
      tick();
      if (n % 50 == 0 || n == 255 || n == 256) begin
        $display("illegal %0d: ill=%0b imm=0x%0h cnt=%0d", n, out_illegal, immediate, illegal_count);
      end
      check($sformatf("ill%0d_flag", n), 64'(out_illegal), 64'd1);
      check($sformatf("ill%0d_imm", n), 64'(immediate), 64'd0);
      check($sformatf("ill%0d_cnt", n), 64'(illegal_count), 64'((n > 255) ? 255 : n));
    end
    in_valid = 1'b0;
    check("ill_cnt64_sat", 64'(illegal_count_w), 64'd255);

    // Reset with two entries queued
    do_reset();
    imm_fmt = 3'd7;
    in_tag = 4'd5;
    in_valid = 1'b1;
    tick();
    imm_fmt = 3'd0;
    instruction = 32'h7FF00013;
    in_tag = 4'd6;
    tick();
    in_valid = 1'b0;
    check("mid_full", 64'(in_ready), 64'd0);
    check("mid_cnt_before", 64'(illegal_count), 64'd1);
    reset_n = 1'b0;
    tick();
    $display("mid reset: out_valid=%0b cnt=%0d in_ready=%0b", out_valid, illegal_count, in_ready);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_cnt", 64'(illegal_count), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_tag", 64'(out_tag), 64'd0);
    check("mid_rst_imm", 64'(immediate), 64'd0);
    reset_n = 1'b1;
    instruction = 32'h00100013;
    imm_fmt = 3'd0;
    in_tag = 4'd9;
    in_valid = 1'b1;
    tick();
    check("mid_rel_ready", 64'(in_ready), 64'd1);
    check("mid_rel_empty", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    $display("mid new entry: out_valid=%0b tag=%0d imm=0x%0h", out_valid, out_tag, immediate);
    check("mid_new_valid", 64'(out_valid), 64'd1);
    check("mid_new_tag", 64'(out_tag), 64'd9);
    check("mid_new_imm", 64'(immediate), 64'd1);
    check("mid_new_ill", 64'(out_illegal), 64'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/immediate_pipe.md
IMMEDIATE_PIPE -- requirements
Module: immediate_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, meaning output FIFO entries; power of two, 2..16.
REQ-003 SHALL have parameter TAG_W, default 4, meaning width of the sideband tag carried with each request.
REQ-004 SHALL have parameter SHAMT_W, default 5, meaning shift-amount field width; 5 for XLEN=32, 6 for XLEN=64.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, meaning reset, synchronous and active-low.
REQ-007 SHALL have port instruction, input, 32, meaning the raw instruction word.
REQ-008 SHALL have port imm_fmt, input, 3, meaning format select: 0 I, 1 S, 2 B, 3 U, 4 J, 5 Z (CSR zimm), 6 SH (shamt), 7 reserved.
REQ-009 SHALL have port in_tag, input, TAG_W, meaning opaque tag returned with the result.
REQ-010 SHALL have port in_valid, input, 1, meaning the request is present.
REQ-011 SHALL have port in_ready, output, 1, meaning the block can accept a request this cycle.
REQ-012 SHALL have port immediate, output, XLEN, meaning the decoded immediate at the FIFO head.
REQ-013 SHALL have port out_tag, output, TAG_W, meaning the tag at the FIFO head.
REQ-014 SHALL have port out_illegal, output, 1, meaning the head entry had imm_fmt=7.
REQ-015 SHALL have port out_valid, output, 1, meaning the head entry is valid.
REQ-016 SHALL have port out_ready, input, 1, meaning the consumer takes the head entry this cycle.
REQ-017 SHALL have port illegal_count, output, 8, meaning a saturating count of accepted illegal-format requests.

Function
REQ-018 SHALL treat a transfer as accepted when in_valid and in_ready are both high at a rising edge, and as popped when out_valid and out_ready are both high.
REQ-019 SHALL drive in_ready = (count != DEPTH), computed from registered state only, with no combinational path from out_ready.
REQ-020 SHALL decode I as sign-extended instruction[31:20], and S as sign-extended {instruction[31:25], instruction[11:7]}.
REQ-021 SHALL decode B as sign-extended {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}.
REQ-022 SHALL decode U as {instruction[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
REQ-023 SHALL decode J as sign-extended {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}.
REQ-024 SHALL decode Z as zero-extended instruction[19:15], and SH as zero-extended instruction[20+SHAMT_W-1:20].
REQ-025 SHALL, for imm_fmt=7, store immediate 0 with out_illegal=1; no output is ever X.
REQ-026 SHALL decode at acceptance and write the decoded value into the FIFO tail, so that an accepted entry appears at the outputs one cycle after acceptance when the FIFO was empty.
REQ-027 SHALL present entries in acceptance order, with immediate, out_tag and out_illegal held stable while out_valid=1 and out_ready=0.
REQ-028 SHALL, on simultaneous accept and pop, leave count unchanged and apply both pointer updates.
REQ-029 SHALL, when full (count=DEPTH), accept only after a pop has lowered count; a simultaneous pop while full does not enable acceptance in that same cycle.
REQ-030 SHALL wrap the read and write pointers modulo DEPTH.
REQ-031 SHALL increment illegal_count on each accepted illegal request, saturating at 255.

Reset
REQ-032 SHALL, while reset_n=0 at a rising edge, clear count, pointers and illegal_count, and force out_valid=0.
REQ-033 SHALL drive in_ready=0 during reset and in_ready=1 on the first cycle after reset_n rises.
REQ-034 SHALL discard all entries in flight when reset is asserted mid-operation; no stale entry reappears after reset.
REQ-035 SHALL drive immediate=0, out_tag=0 and out_illegal=0 after reset until the first entry is written.

Verification
REQ-036 SHALL check XLEN=32: I with 0xFFF00093 -> 0xFFFFFFFF; B with 0xFE000EE3 -> 0xFFFFFFFC; U with 0x12345037 -> 0x12345000; Z with 0x000F8073 -> 0x0000001F.
REQ-037 SHALL check XLEN=64, SHAMT_W=6: U with 0x80000037 -> 0xFFFFFFFF80000000; SH with 0x03F01013 -> 0x3F.
REQ-038 SHALL check DEPTH=2 with out_ready=0: after 2 accepts, in_ready=0; then out_ready=1 pops in order (tags 1, 2), and in_ready returns to 1.
REQ-039 SHALL check streaming with in_valid=1 and out_ready=1 continuously: one result per cycle, count stays 1, tags emerge in order.
REQ-040 SHALL check imm_fmt=7 repeated 300 times: out_illegal=1, immediate=0, and illegal_count saturates at 255.
REQ-041 SHALL check reset_n=0 asserted with 2 entries queued: the next cycle shows out_valid=0 and illegal_count=0, and after release the first new entry carries its own tag.
